// File: rtl/mul_op_unpack_pkg.sv
// Shared FP operand-unpack definitions: operand classes, default field widths,
// bias helper and the quiet-NaN mantissa pattern.
package mul_op_unpack_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    localparam int EXPO_W_DEF = 8;
    localparam int MANT_W_DEF = 23;

    function automatic int bias_of(input int expo_w);
        return (2 ** (expo_w - 1)) - 1;
    endfunction

    localparam int BIAS_DEF = bias_of(EXPO_W_DEF);

    // Quiet NaN: only the top stored mantissa bit set.
    localparam logic [MANT_W_DEF-1:0] QNAN_MANT_DEF = {1'b1, {(MANT_W_DEF-1){1'b0}}};

    typedef struct packed {
        logic                  sign;
        logic [EXPO_W_DEF-1:0] expo;
        logic [MANT_W_DEF-1:0] mant;
    } fp_unpack_t;

endpackage

// File: rtl/mul_op_unpack_if.sv
// Operand/result handshake bundle of the FP multiplier front end.
// master = upstream/downstream side, slave = the unpack block.
interface mul_op_unpack_if #(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
);
    logic                       in_valid;
    logic                       in_ready;
    logic [EXPO_W+MANT_W:0]     op_a;
    logic [EXPO_W+MANT_W:0]     op_b;
    logic                       out_valid;
    logic                       out_ready;
    logic                       sign_1;
    logic                       is_inf_nan;
    logic                       sign_nan;
    logic [MANT_W-1:0]          mant_4;
    logic                       is_zero;
    logic [MANT_W:0]            mant_a;
    logic [MANT_W:0]            mant_b;
    logic signed [EXPO_W+1:0]   expo_sum;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, sign_1, is_inf_nan, sign_nan, mant_4,
               is_zero, mant_a, mant_b, expo_sum
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, sign_1, is_inf_nan, sign_nan, mant_4,
               is_zero, mant_a, mant_b, expo_sum
    );
endinterface

// File: rtl/mul_op_unpack_classify.sv
// Combinational per-operand field split and class decode.
module mul_op_unpack_classify
    import mul_op_unpack_pkg::*;
#(
    parameter int EXPO_W = EXPO_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic [EXPO_W+MANT_W:0] op,
    output fp_class_e              cls,
    output logic                   sign,
    output logic [EXPO_W-1:0]      expo,
    output logic [MANT_W-1:0]      mant
);
    assign sign = op[EXPO_W+MANT_W];
    assign expo = op[EXPO_W+MANT_W-1:MANT_W];
    assign mant = op[MANT_W-1:0];

    // Class from exponent all-zeros / all-ones and mantissa zero test.
    always_comb begin
        cls = CLS_NORM;
        if (expo == '0)
            cls = (mant == '0) ? CLS_ZERO : CLS_SUB;
        else if (expo == '1)
            cls = (mant == '0) ? CLS_INF : CLS_NAN;
    end
endmodule

// File: rtl/mul_op_unpack.sv
// FP multiplier operand front end: classifies both operands, normalizes
// subnormals one bit per cycle, emits unpacked mantissas, biased exponent sum
// and special-case flags over valid/ready.
// Build option: MUL_UNPACK_DAZ_EN treats subnormal inputs as signed zero and
// removes the normalization states (latency always 1).
module mul_op_unpack
    import mul_op_unpack_pkg::*;
#(
    parameter int EXPO_W = EXPO_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    mul_op_unpack_if.slave  bus
);
    localparam int SUM_W = EXPO_W + 2;
    localparam logic signed [SUM_W-1:0] BIAS     = SUM_W'(bias_of(EXPO_W));
    localparam logic signed [SUM_W-1:0] SUM_ONE  = SUM_W'(1);
    localparam logic [MANT_W-1:0]       QNAN_MANT = {1'b1, {(MANT_W-1){1'b0}}};

    fp_class_e              cls_a, cls_b;
    logic                   sign_a, sign_b;
    logic [EXPO_W-1:0]      expo_a, expo_b;
    logic [MANT_W-1:0]      frac_a, frac_b;

    mul_op_unpack_classify #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_a (
        .op(bus.op_a), .cls(cls_a), .sign(sign_a), .expo(expo_a), .mant(frac_a)
    );
    mul_op_unpack_classify #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_b (
        .op(bus.op_b), .cls(cls_b), .sign(sign_b), .expo(expo_b), .mant(frac_b)
    );

    logic                   out_valid_q, sign_1_q, is_inf_nan_q, sign_nan_q, is_zero_q;
    logic [MANT_W-1:0]      mant_4_q;
    logic [MANT_W:0]        mant_a_q, mant_b_q;
    logic signed [SUM_W-1:0] expo_sum_q;
    logic                   idle, in_ready, accept;

`ifndef MUL_UNPACK_DAZ_EN
    typedef enum logic [1:0] {ST_IDLE, ST_NORM_A, ST_NORM_B} state_e;
    state_e state;
    assign idle = (state == ST_IDLE);
`else
    assign idle = 1'b1;
`endif

    // The "result ready" phase is IDLE with out_valid set, so a new pair can be
    // taken on the same edge the pending result is consumed.
    assign in_ready = rst_n && idle && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    logic                    zero_a, zero_b, any_nan, any_inf, any_zero, nan_res;
    logic                    need_a, need_b;
    logic signed [SUM_W-1:0] ea0, eb0, sum0;
    logic [MANT_W:0]         ma0, mb0;

    // Accept-time decode: special-case precedence, load values, NORM need.
    always_comb begin
        zero_a = (cls_a == CLS_ZERO);
        zero_b = (cls_b == CLS_ZERO);
`ifdef MUL_UNPACK_DAZ_EN
        zero_a = zero_a || (cls_a == CLS_SUB);
        zero_b = zero_b || (cls_b == CLS_SUB);
`endif
        any_nan  = (cls_a == CLS_NAN) || (cls_b == CLS_NAN);
        any_inf  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
        any_zero = zero_a || zero_b;
        nan_res  = any_nan || (any_inf && any_zero);
        need_a   = 1'b0;
        need_b   = 1'b0;
`ifndef MUL_UNPACK_DAZ_EN
        need_a = !any_nan && !any_inf && !any_zero && (cls_a == CLS_SUB);
        need_b = !any_nan && !any_inf && !any_zero && (cls_b == CLS_SUB);
`endif
        ma0  = {(cls_a != CLS_ZERO) && (cls_a != CLS_SUB), frac_a};
        mb0  = {(cls_b != CLS_ZERO) && (cls_b != CLS_SUB), frac_b};
        ea0  = (cls_a == CLS_SUB) ? SUM_ONE : signed'({2'b00, expo_a});
        eb0  = (cls_b == CLS_SUB) ? SUM_ONE : signed'({2'b00, expo_b});
        sum0 = ea0 + eb0 - BIAS;
    end

    // Handshake, output registers and subnormal normalization.
    // The exponent sum is formed at accept and decremented per shift, which is
    // equivalent to decrementing the operand's effective exponent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            sign_1_q     <= 1'b0;
            is_inf_nan_q <= 1'b0;
            sign_nan_q   <= 1'b0;
            mant_4_q     <= '0;
            is_zero_q    <= 1'b0;
            mant_a_q     <= '0;
            mant_b_q     <= '0;
            expo_sum_q   <= '0;
`ifndef MUL_UNPACK_DAZ_EN
            state        <= ST_IDLE;
`endif
        end else begin
            if (accept) begin
                sign_1_q     <= sign_a ^ sign_b;
                is_inf_nan_q <= nan_res || any_inf;
                sign_nan_q   <= !nan_res && any_inf && (sign_a ^ sign_b);
                mant_4_q     <= nan_res ? QNAN_MANT : '0;
                is_zero_q    <= !any_nan && !any_inf && any_zero;
                mant_a_q     <= ma0;
                mant_b_q     <= mb0;
                expo_sum_q   <= sum0;
                out_valid_q  <= !(need_a || need_b);
            end else if (bus.out_ready) begin
                out_valid_q  <= 1'b0;
            end
`ifndef MUL_UNPACK_DAZ_EN
            case (state)
                ST_IDLE: begin
                    if (accept)
                        state <= need_a ? ST_NORM_A : (need_b ? ST_NORM_B : ST_IDLE);
                end
                ST_NORM_A: begin
                    mant_a_q   <= mant_a_q << 1;
                    expo_sum_q <= expo_sum_q - SUM_ONE;
                    if (mant_a_q[MANT_W-1]) begin
                        if (!mant_b_q[MANT_W]) begin
                            state <= ST_NORM_B;
                        end else begin
                            state       <= ST_IDLE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_NORM_B: begin
                    mant_b_q   <= mant_b_q << 1;
                    expo_sum_q <= expo_sum_q - SUM_ONE;
                    if (mant_b_q[MANT_W-1]) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`endif
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.sign_1     = sign_1_q;
    assign bus.is_inf_nan = is_inf_nan_q;
    assign bus.sign_nan   = sign_nan_q;
    assign bus.mant_4     = mant_4_q;
    assign bus.is_zero    = is_zero_q;
    assign bus.mant_a     = mant_a_q;
    assign bus.mant_b     = mant_b_q;
    assign bus.expo_sum   = expo_sum_q;
endmodule

// File: tb/tb_mul_op_unpack.sv
// Testbench for mul_op_unpack (EXPO_W=8, MANT_W=23): directed cases plus
// randomized operand pairs against a behavioural IEEE-754 unpack model.
// Honours MUL_UNPACK_DAZ_EN in the model when defined.
module tb_mul_op_unpack;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_op_unpack_if #(.EXPO_W(8), .MANT_W(23)) bus ();

    mul_op_unpack #(.EXPO_W(8), .MANT_W(23)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    typedef struct {
        int sign_1, is_inf_nan, sign_nan, mant_4, is_zero;
        int mant_a, mant_b, expo_sum, lat;
        bit data_ok;
    } exp_t;

    // Reference: classify, apply special precedence, normalize by arithmetic.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int ea, eb, fa, fb, ma, mb, xa, xb, shifts;
        bit daz, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
`ifdef MUL_UNPACK_DAZ_EN
        daz = 1'b1;
`else
        daz = 1'b0;
`endif
        ea = int'(a[30:23]); fa = int'(a[22:0]);
        eb = int'(b[30:23]); fb = int'(b[22:0]);
        a_nan  = (ea == 255) && (fa != 0);  b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);  b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0) && ((fa == 0) || daz);
        b_zero = (eb == 0) && ((fb == 0) || daz);
        r = '{default: 0};
        r.sign_1 = int'(a[31] ^ b[31]);
        shifts = 0;
        if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) begin
            r.is_inf_nan = 1;
            r.mant_4     = 32'h0040_0000;
        end else if (a_inf || b_inf) begin
            r.is_inf_nan = 1;
            r.sign_nan   = r.sign_1;
        end else if (a_zero || b_zero) begin
            r.is_zero = 1;
        end else begin
            ma = (ea == 0) ? fa : fa + (1 << 23);
            mb = (eb == 0) ? fb : fb + (1 << 23);
            xa = (ea == 0) ? 1 : ea;
            xb = (eb == 0) ? 1 : eb;
            while (ma < (1 << 23)) begin ma = ma * 2; xa = xa - 1; shifts++; end
            while (mb < (1 << 23)) begin mb = mb * 2; xb = xb - 1; shifts++; end
            r.mant_a   = ma;
            r.mant_b   = mb;
            r.expo_sum = xa + xb - 127;
            r.data_ok  = 1'b1;
        end
        r.lat = 1 + shifts;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        int          sel;
        sel = int'($urandom_range(0, 9));
        s   = 1'($urandom_range(0, 1));
        case (sel)
            0: begin e = 8'h00; m = '0; end
            1: begin e = 8'h00; m = 23'($urandom_range(1, 32'h7F_FFFF)); end
            2: begin e = 8'h00; m = 23'(1) << $urandom_range(0, 22); end
            3: begin e = 8'hFF; m = '0; end
            4: begin e = 8'hFF; m = 23'($urandom_range(1, 32'h7F_FFFF)); end
            default: begin e = 8'($urandom_range(1, 254)); m = 23'($urandom()); end
        endcase
        return {s, e, m};
    endfunction

    task automatic check_fields(input string tag, input exp_t e);
        check_eq({tag, "_sign_1"},     int'(bus.sign_1),     e.sign_1);
        check_eq({tag, "_is_inf_nan"}, int'(bus.is_inf_nan), e.is_inf_nan);
        check_eq({tag, "_sign_nan"},   int'(bus.sign_nan),   e.sign_nan);
        check_eq({tag, "_mant_4"},     int'(bus.mant_4),     e.mant_4);
        check_eq({tag, "_is_zero"},    int'(bus.is_zero),    e.is_zero);
        if (e.data_ok) begin
            check_eq({tag, "_mant_a"},   int'(bus.mant_a),   e.mant_a);
            check_eq({tag, "_mant_b"},   int'(bus.mant_b),   e.mant_b);
            check_eq({tag, "_expo_sum"}, int'(bus.expo_sum), e.expo_sum);
        end
    endtask

    // Present one pair, measure latency, optionally stall, check, consume.
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                            input int stall, input string tag);
        exp_t e;
        int   n, lat;
        e = ref_model(a, b);
        bus.out_ready = 1'b0;
        bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 10) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) begin
            check_eq({tag, "_accept_timeout"}, 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check_eq({tag, "_latency"}, lat, e.lat);
        repeat (stall) begin @(posedge clk); #1; end
        check_eq({tag, "_valid_held"}, int'(bus.out_valid), 1);
        check_eq({tag, "_ready_blocked"}, int'(bus.in_ready), 0);
        check_fields(tag, e);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        exp_t e2;
        int   seen;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_in_ready",  int'(bus.in_ready),  0);
        check_eq("rst_mant_a",    int'(bus.mant_a),    0);
        check_eq("rst_expo_sum",  int'(bus.expo_sum),  0);
        check_eq("rst_mant_4",    int'(bus.mant_4),    0);
        rst_n = 1'b1;
        #1;
        check_eq("idle_in_ready", int'(bus.in_ready), 1);

        run_pair(32'h3F80_0000, 32'h4000_0000, 0, "one_two");
        run_pair(32'h0000_0001, 32'h3F80_0000, 0, "min_sub");
        run_pair(32'h3F80_0000, 32'h0000_0001, 1, "sub_b");
        run_pair(32'h0040_0000, 32'h8000_0003, 0, "two_sub");
        run_pair(32'h7F80_0000, 32'h0000_0000, 0, "inf_zero");
        run_pair(32'hFF80_0000, 32'h3F80_0000, 0, "neg_inf");
        run_pair(32'h7FC0_0001, 32'hFF80_0000, 0, "nan_inf");
        run_pair(32'h8000_0000, 32'h4120_0000, 0, "neg_zero");
        run_pair(32'h7F7F_FFFF, 32'h7F7F_FFFF, 0, "max_norm");

        // Backpressure: pending result held 5 cycles while a new pair waits.
        run_pair(32'h3F80_0000, 32'h4000_0000, 5, "bp_hold");
        bus.op_a = 32'h3F80_0000; bus.op_b = 32'h4000_0000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_a = 32'h4040_0000; bus.op_b = 32'hC080_0000;
        while (!bus.out_valid) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_in_ready_low", int'(bus.in_ready), 0);
            check_eq("bp_expo_stable", int'(bus.expo_sum), 128);
            check_eq("bp_mant_b_stable", int'(bus.mant_b), 32'h80_0000);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_same_cycle_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        e2 = ref_model(32'h4040_0000, 32'hC080_0000);
        check_eq("bp_next_valid", int'(bus.out_valid), 1);
        check_fields("bp_next", e2);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset during normalization of the minimum subnormal.
        bus.op_a = 32'h0000_0001; bus.op_b = 32'h3F80_0000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rst_mid_valid", int'(bus.out_valid), 0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check_eq("rst_mid_no_result", seen, 0);
        run_pair(32'h3F80_0000, 32'h4000_0000, 0, "after_rst");

        for (int i = 0; i < 150; i++)
            run_pair(rand_op(), rand_op(), int'($urandom_range(0, 2)), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end
endmodule
